ir_nec_key_decode: RTL and testbench
====================================

// Module: ir_nec_key_decode
// PURPOSE
//  Consumes the raw 32-bit NEC frames delivered by the IR receiver and turns them into clean key events.
//  - Validates the address and command complements.
//  - Optionally filters on one remote address.
//  - Tracks NEC repeat codes to maintain a key-held state and generate auto-repeat events.
//  Sits between the IR Rx stage and the display/control logic.
// PARAMETERS
//  CLK_HZ          50_000_000  system clock frequency; sets the 1 ms tick prescaler
//  RPT_TIMEOUT_MS  120         ms without a repeat code before a held key is released
//  RPT_DELAY       4           repeat codes received before the first auto-repeat event
//  RPT_DIV         2           after RPT_DELAY, one auto-repeat event every RPT_DIV repeat codes
//  EXT_ADDR_EN     0           1: bits[23:16] form an extended address, so no address complement check
//  ADDR_FILT_EN    0           1: drop valid frames whose 16-bit address differs from ADDR_MATCH
//  ADDR_MATCH      16'h00FF    address accepted when ADDR_FILT_EN=1
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  i_frame      in   32  {addr[31:24], addr_n/ext[23:16], cmd[15:8], cmd_n[7:0]}
//  i_frame_vld  in   1   1-cycle strobe; i_frame is valid on this cycle
//  i_rpt_vld    in   1   1-cycle strobe; NEC repeat code detected
//  o_key_vld    out  1   1-cycle key event strobe
//  o_key_cmd    out  8   command of the current/last key
//  o_key_addr   out  16  {addr, addr_n/ext} of the current/last key
//  o_key_rpt    out  1   qualifies o_key_vld: 0 = new press, 1 = auto-repeat
//  o_key_held   out  1   level; high while in HELD
//  o_err        out  1   1-cycle strobe on a complement-check failure
//  o_err_cnt    out  8   saturating count of complement failures
// BEHAVIOUR
//  Reset: all outputs are 0, state is IDLE, and all counters are 0. Reset mid-HELD drops the key with no event.
//  1 ms tick: internal prescaler counts 0..CLK_HZ/1000-1 and pulses for one clk at wrap; it free-runs from reset.
//  Frame check (on i_frame_vld):
//   - cmd_ok  = (i_frame[15:8] == ~i_frame[7:0])
//   - addr_ok = EXT_ADDR_EN | (i_frame[31:24] == ~i_frame[23:16])
//   - !cmd_ok or !addr_ok:
//     - o_err pulses on the next cycle
//     - o_err_cnt increments, saturating at 8'hFF
//     - state goes to IDLE, o_key_held falls, no key event
//   - Checks pass but filter mismatch: frame dropped silently; state, outputs and counters are unchanged.
//   - Checks pass and filter passes:
//     - next cycle: o_key_vld=1, o_key_rpt=0, cmd/addr registered
//     - state goes to HELD (also from HELD with a new key)
//     - timeout counter reloads to RPT_TIMEOUT_MS; repeat counter clears
//  Latency: i_frame_vld/i_rpt_vld to o_key_vld/o_err is exactly 1 clk.
//  FSM:
//   - IDLE: i_rpt_vld is ignored.
//   - HELD, on i_rpt_vld:
//     - reload timeout; rpt_cnt++, saturating at RPT_DELAY+RPT_DIV
//     - when rpt_cnt reaches RPT_DELAY, emit o_key_vld=1, o_key_rpt=1 with the stored cmd/addr
//     - thereafter emit one event every RPT_DIV repeat codes (rpt_cnt wraps back to RPT_DELAY)
//   - HELD, on 1 ms tick: timeout--; at 0, go to IDLE with no event.
//  Simultaneous events:
//   - i_frame_vld and i_rpt_vld together: the frame wins and the repeat is discarded.
//   - Tick coincident with i_rpt_vld: the reload wins.
//  o_key_cmd/o_key_addr hold their last value in IDLE. o_key_rpt is valid only while o_key_vld=1; it is 0 otherwise.
// STRUCTURE
//  Shared package (ir_pkg):
//   - NEC field bit positions: ADDR_MSB/LSB, ADDRN, CMD, CMDN
//   - state encoding: IDLE=1'b0, HELD=1'b1
//   - width constants: FRAME_W=32, CMD_W=8, ADDR_W=16
//  Sub-module ir_ms_tick (CLK_HZ param, clk/rst, o_tick). Reused later by other IR timing blocks.
//  Top: frame checker (combinational) + registered FSM / timeout / repeat counters / output registers.
// TESTING  (CLK_HZ scaled to 10_000 in sim; 1 ms = 10 clk)
//  1. Valid frame:
//     - stimulus: i_frame=32'h00FF_16E9 (addr 00, cmd 16), 1 strobe
//     - response: next clk o_key_vld=1, o_key_rpt=0, o_key_cmd=8'h16, o_key_addr=16'h00FF, o_key_held=1
//  2. Command complement failure:
//     - stimulus: i_frame=32'h00FF_1616
//     - response: o_err pulse 1 clk, o_err_cnt=1, no o_key_vld, o_key_held=0; 300 bad frames leave o_err_cnt=8'hFF
//  3. Auto-repeat:
//     - stimulus: valid frame, then 10 i_rpt_vld spaced 108 ms
//     - response: exactly 1 press + auto-repeats on repeats #4,#6,#8,#10 (rpt=1, cmd=8'h16); o_key_held stays 1
//  4. Timeout:
//     - stimulus: valid frame, no repeats
//     - response: o_key_held falls 120 ms (±1 tick) later; a later i_rpt_vld produces nothing
//  5. Address filter:
//     - stimulus: ADDR_FILT_EN=1, ADDR_MATCH=16'h00FF; frame 32'h01FE_16E9
//     - response: dropped (no vld, no err); a frame with addr 16'h00FF is then accepted
//  6. Collision and reset:
//     - stimulus: i_frame_vld+i_rpt_vld in the same cycle
//     - response: a single press event with rpt=0
//     - stimulus: rst asserted while HELD
//     - response: all outputs 0 immediately

Source files
------------

// File: rtl/ir_pkg.sv
// Shared IR definitions: NEC field positions, widths and key FSM states.
// Also provides the complement check used by the frame decoder.
package ir_pkg;

  localparam int FRAME_W = 32;
  localparam int CMD_W   = 8;
  localparam int ADDR_W  = 16;

  localparam int ADDR_MSB  = 31;
  localparam int ADDR_LSB  = 24;
  localparam int ADDRN_MSB = 23;
  localparam int ADDRN_LSB = 16;
  localparam int CMD_MSB   = 15;
  localparam int CMD_LSB   = 8;
  localparam int CMDN_MSB  = 7;
  localparam int CMDN_LSB  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  function automatic logic cmpl_ok(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a == ~b;
  endfunction

endpackage

// File: rtl/ir_nec_key_decode_if.sv
// Frame/repeat strobes from the IR receiver and the decoded key event bus.
// master drives the strobes, slave is the key decoder.
interface ir_nec_key_decode_if;
  import ir_pkg::*;

  logic [FRAME_W-1:0] i_frame;
  logic               i_frame_vld;
  logic               i_rpt_vld;
  logic               o_key_vld;
  logic [CMD_W-1:0]   o_key_cmd;
  logic [ADDR_W-1:0]  o_key_addr;
  logic               o_key_rpt;
  logic               o_key_held;
  logic               o_err;
  logic [7:0]         o_err_cnt;

  modport master (
    output i_frame, i_frame_vld, i_rpt_vld,
    input  o_key_vld, o_key_cmd, o_key_addr,
    input  o_key_rpt, o_key_held, o_err, o_err_cnt
  );

  modport slave (
    input  i_frame, i_frame_vld, i_rpt_vld,
    output o_key_vld, o_key_cmd, o_key_addr,
    output o_key_rpt, o_key_held, o_err, o_err_cnt
  );

endinterface

// File: rtl/ir_ms_tick.sv
// Free-running 1 ms prescaler; o_tick is high for one clk at each wrap.
module ir_ms_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_nec_key_decode.sv
// Turns raw NEC frames and repeat codes into press / auto-repeat key events.
// Tracks the held key with a ms timeout and counts complement failures.
module ir_nec_key_decode
  import ir_pkg::*;
#(
  parameter int          CLK_HZ         = 50_000_000,
  parameter int          RPT_TIMEOUT_MS = 120,
  parameter int          RPT_DELAY      = 4,
  parameter int          RPT_DIV        = 2,
  parameter bit          EXT_ADDR_EN    = 1'b0,
  parameter bit          ADDR_FILT_EN   = 1'b0,
  parameter logic [15:0] ADDR_MATCH     = 16'h00FF
) (
  input logic               clk,
  input logic               rst,
  ir_nec_key_decode_if.slave io_bus
);

  localparam int TW = $clog2(RPT_TIMEOUT_MS + 1);
  localparam int RW = $clog2(RPT_DELAY + RPT_DIV + 1);

  state_e            r_state;
  state_e            w_state_nx;
  logic [TW-1:0]     r_tmo;
  logic [TW-1:0]     w_tmo_nx;
  logic [RW-1:0]     r_rpt_cnt;
  logic [RW-1:0]     w_rpt_nx;
  logic [RW-1:0]     w_rpt_inc;
  logic              w_emit_rpt;

  logic              r_key_vld;
  logic              r_key_rpt;
  logic [CMD_W-1:0]  r_key_cmd;
  logic [ADDR_W-1:0] r_key_addr;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  logic              w_tick;
  logic              w_fvld;
  logic              w_rpt;
  logic              w_cmd_ok;
  logic              w_addr_ok;
  logic              w_filt_ok;
  logic              w_accept;
  logic              w_bad;
  logic [ADDR_W-1:0] w_addr;

  ir_ms_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_fvld    = io_bus.i_frame_vld;
  assign w_addr    = io_bus.i_frame[ADDR_MSB:ADDRN_LSB];
  assign w_cmd_ok  = cmpl_ok(io_bus.i_frame[CMD_MSB:CMD_LSB],
                             io_bus.i_frame[CMDN_MSB:CMDN_LSB]);
  assign w_addr_ok = EXT_ADDR_EN ||
                     cmpl_ok(io_bus.i_frame[ADDR_MSB:ADDR_LSB],
                             io_bus.i_frame[ADDRN_MSB:ADDRN_LSB]);
  assign w_filt_ok = !ADDR_FILT_EN || (w_addr == ADDR_MATCH);
  assign w_bad     = w_fvld && !(w_cmd_ok && w_addr_ok);
  assign w_accept  = w_fvld && w_cmd_ok && w_addr_ok && w_filt_ok;
  // A frame in the same cycle swallows the repeat code
  assign w_rpt     = io_bus.i_rpt_vld && !w_fvld;
  assign w_rpt_inc = r_rpt_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tmo     <= '0;
      r_rpt_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_tmo     <= w_tmo_nx;
      r_rpt_cnt <= w_rpt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_tmo_nx   = r_tmo;
    w_rpt_nx   = r_rpt_cnt;
    w_emit_rpt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = HELD;
          w_tmo_nx   = TW'(RPT_TIMEOUT_MS);
          w_rpt_nx   = '0;
        end
      end
      HELD: begin
        if (w_bad) begin
          w_state_nx = IDLE;
        end else if (w_accept) begin
          w_tmo_nx = TW'(RPT_TIMEOUT_MS);
          w_rpt_nx = '0;
        end else if (w_rpt) begin
          w_tmo_nx = TW'(RPT_TIMEOUT_MS);
          // Wrap to RPT_DELAY so every RPT_DIV-th repeat fires
          if (w_rpt_inc == RW'(RPT_DELAY)) begin
            w_rpt_nx   = w_rpt_inc;
            w_emit_rpt = 1'b1;
          end else if (w_rpt_inc >= RW'(RPT_DELAY + RPT_DIV)) begin
            w_rpt_nx   = RW'(RPT_DELAY);
            w_emit_rpt = 1'b1;
          end else begin
            w_rpt_nx = w_rpt_inc;
          end
        end else if (w_tick && !w_fvld) begin
          w_tmo_nx = r_tmo - 1'b1;
          if (r_tmo <= TW'(1)) begin
            w_state_nx = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_vld  <= 1'b0;
      r_key_rpt  <= 1'b0;
      r_key_cmd  <= '0;
      r_key_addr <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_key_vld <= w_accept || w_emit_rpt;
      r_key_rpt <= w_emit_rpt;
      r_err     <= w_bad;
      if (w_bad && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_accept) begin
        r_key_cmd  <= io_bus.i_frame[CMD_MSB:CMD_LSB];
        r_key_addr <= w_addr;
      end
    end
  end

  assign io_bus.o_key_vld  = r_key_vld;
  assign io_bus.o_key_rpt  = r_key_rpt;
  assign io_bus.o_key_cmd  = r_key_cmd;
  assign io_bus.o_key_addr = r_key_addr;
  assign io_bus.o_key_held = (r_state == HELD);
  assign io_bus.o_err      = r_err;
  assign io_bus.o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_ir_nec_key_decode.sv
// Randomized and directed bench for ir_nec_key_decode against an event-level key model.
// 1 ms is scaled to 10 clk.
module tb_ir_nec_key_decode;
  import ir_pkg::*;

  localparam int CLK_HZ = 10_000;
  localparam int MS     = 10;
  localparam int TMO    = 120;
  localparam int DLY    = 4;
  localparam int DIV    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_nec_key_decode_if bus ();
  ir_nec_key_decode_if fbus ();

  ir_nec_key_decode #(
    .CLK_HZ (CLK_HZ)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  ir_nec_key_decode #(
    .CLK_HZ       (CLK_HZ),
    .ADDR_FILT_EN (1'b1),
    .ADDR_MATCH   (16'h00FF)
  ) u_flt (
    .clk    (clk),
    .rst    (rst),
    .io_bus (fbus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_rpt_seen = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bit          m_held = 0;
  logic [7:0]  m_cmd  = '0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_ecnt = '0;
  int          m_rpts = 0;
  int unsigned m_last = 0;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {a, ~a, c, ~c};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("quiet", {bus.o_key_vld, bus.o_err}, 0);
    end
  endtask

  // kind: 0 frame, 1 repeat, 2 frame and repeat together
  task automatic ev(input int kind, input logic [31:0] fr);
    logic e_vld, e_rpt, e_err;
    bit   cok, aok;
    e_vld = 0;
    e_rpt = 0;
    e_err = 0;
    if (m_held && (cyc - m_last) > TMO * MS) m_held = 0;
    if (kind != 1) begin
      cok = (fr[15:8] == ~fr[7:0]);
      aok = (fr[31:24] == ~fr[23:16]);
      if (!(cok && aok)) begin
        e_err = 1;
        if (m_ecnt != 8'hFF) m_ecnt++;
        m_held = 0;
      end else begin
        e_vld  = 1;
        m_cmd  = fr[15:8];
        m_addr = fr[31:16];
        m_held = 1;
        m_rpts = 0;
        m_last = cyc;
      end
    end else if (m_held) begin
      m_rpts++;
      m_last = cyc;
      if (m_rpts >= DLY && ((m_rpts - DLY) % DIV) == 0) begin
        e_vld = 1;
        e_rpt = 1;
      end
    end
    bus.i_frame     = fr;
    bus.i_frame_vld = (kind != 1);
    bus.i_rpt_vld   = (kind != 0);
    @(negedge clk);
    bus.i_frame_vld = 0;
    bus.i_rpt_vld   = 0;
    chk("key_vld", bus.o_key_vld, e_vld);
    chk("key_rpt", bus.o_key_rpt, e_rpt);
    chk("key_cmd", bus.o_key_cmd, m_cmd);
    chk("key_addr", bus.o_key_addr, m_addr);
    chk("key_held", bus.o_key_held, m_held);
    chk("err", bus.o_err, e_err);
    chk("err_cnt", bus.o_err_cnt, m_ecnt);
    if (bus.o_key_vld && bus.o_key_rpt) n_rpt_seen++;
  endtask

  initial begin
    int k;
    int gap;
    int sel;
    int b;
    logic [31:0] fr;

    bus.i_frame      = '0;
    bus.i_frame_vld  = 0;
    bus.i_rpt_vld    = 0;
    fbus.i_frame     = '0;
    fbus.i_frame_vld = 0;
    fbus.i_rpt_vld   = 0;

    repeat (3) @(negedge clk);
    chk("rst_a", {bus.o_key_vld, bus.o_key_rpt, bus.o_key_held, bus.o_err,
                  bus.o_key_cmd, bus.o_err_cnt}, 0);
    chk("rst_b", bus.o_key_addr, 0);
    rst = 0;
    idle(5);

    // valid frame
    ev(0, 32'h00FF_16E9);
    chk("t1_addr", bus.o_key_addr, 16'h00FF);
    idle(20);

    // complement failure then saturation
    ev(0, 32'h00FF_1616);
    chk("t2_cnt", bus.o_err_cnt, 1);
    chk("t2_held", bus.o_key_held, 0);
    idle(5);
    repeat (300) ev(0, 32'h00FF_1616);
    chk("t2_sat", bus.o_err_cnt, 8'hFF);
    idle(5);

    // auto-repeat: ten repeats 108 ms apart
    n_rpt_seen = 0;
    ev(0, 32'h00FF_16E9);
    for (int i = 0; i < 10; i++) begin
      idle(108 * MS - 1);
      ev(1, 32'h0);
    end
    chk("t3_rpts", n_rpt_seen, 4);
    chk("t3_held", bus.o_key_held, 1);

    // timeout
    idle(20);
    ev(0, mk(8'h00, 8'h16));
    k = 0;
    while (bus.o_key_held && k < 1300) begin
      @(negedge clk);
      chk("t4_quiet", bus.o_key_vld, 0);
      k++;
    end
    chk("t4_window", (k >= (TMO - 1) * MS) && (k <= (TMO + 1) * MS), 1);
    idle(50);
    ev(1, 32'h0);
    idle(5);

    // collision: frame wins over repeat
    ev(0, mk(8'h00, 8'h16));
    idle(3);
    ev(2, mk(8'h22, 8'h45));
    chk("t6_rpt", bus.o_key_rpt, 0);
    idle(3);

    // reset while held
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t6_rst_a", {bus.o_key_vld, bus.o_key_rpt, bus.o_key_held, bus.o_err,
                     bus.o_key_cmd, bus.o_err_cnt}, 0);
    chk("t6_rst_b", bus.o_key_addr, 0);
    @(negedge clk);
    rst    = 0;
    m_held = 0;
    m_cmd  = '0;
    m_addr = '0;
    m_ecnt = '0;
    m_rpts = 0;
    idle(5);

    // random traffic
    for (int i = 0; i < 50; i++) begin
      gap = ($urandom_range(0, 9) < 8) ? $urandom_range(2, 600)
                                        : $urandom_range(1400, 1600);
      idle(gap - 1);
      sel = $urandom_range(0, 19);
      fr  = mk(8'($urandom), 8'($urandom));
      if (sel < 8) begin
        ev(0, fr);
      end else if (sel < 10) begin
        b = $urandom_range(0, 15);
        if (b >= 8) b += 8;
        ev(0, fr ^ (32'h1 << b));
      end else if (sel < 19) begin
        ev(1, 32'h0);
      end else begin
        ev(2, fr);
      end
    end

    // address filter instance
    @(negedge clk);
    fbus.i_frame     = 32'h01FE_16E9;
    fbus.i_frame_vld = 1;
    @(negedge clk);
    fbus.i_frame_vld = 0;
    chk("t5_drop_vld", fbus.o_key_vld, 0);
    chk("t5_drop_err", fbus.o_err, 0);
    chk("t5_drop_held", fbus.o_key_held, 0);
    fbus.i_frame     = 32'h00FF_16E9;
    fbus.i_frame_vld = 1;
    @(negedge clk);
    fbus.i_frame_vld = 0;
    chk("t5_acc_vld", fbus.o_key_vld, 1);
    chk("t5_acc_addr", fbus.o_key_addr, 16'h00FF);
    chk("t5_acc_cmd", fbus.o_key_cmd, 8'h16);
    chk("t5_acc_held", fbus.o_key_held, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
